// File: rtl/dc_restorer_pkg.sv
// Shared DSP package for the DC blocker / DC restorer chain.
// Holds the restorer state type, default widths and the saturating
// narrow helper used by both the blocker and the restorer.
package dsp_pkg;

    localparam int unsigned WIDTH_DEF = 12;
    localparam int unsigned K_DEF     = 4;
    localparam int unsigned GUARD_DEF = 6;

    typedef enum logic {PRIME, RUN} restorer_state_t;

    // Clip a wide signed value into the signed range of a w-bit word.
    // The result is returned sign-extended to 64 bits.
    function automatic logic signed [63:0] sat_narrow(input logic signed [63:0] acc,
                                                      input int unsigned w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (acc > hi) return hi;
        if (acc < lo) return lo;
        return acc;
    endfunction

endpackage

// File: rtl/dc_restorer_if.sv
// Sample bus of the DC restorer.
//   sampl_freq : sample-rate strobe (level), one update per rising edge
//   clear      : synchronous re-prime request
//   data_in    : signed sample from the DC blocker
//   data_out   : signed restored sample (saturated)
//   data_valid : one-clock pulse when data_out updates
//   sat        : sticky saturation flag
// master = sample source / consumer, slave = dc_restorer.
interface dc_restorer_if import dsp_pkg::*; #(
    parameter int unsigned width = WIDTH_DEF
);
    logic                    sampl_freq;
    logic                    clear;
    logic signed [width-1:0] data_in;
    logic signed [width-1:0] data_out;
    logic                    data_valid;
    logic                    sat;

    modport master (output sampl_freq, clear, data_in,
                    input  data_out, data_valid, sat);
    modport slave  (input  sampl_freq, clear, data_in,
                    output data_out, data_valid, sat);
endinterface

// File: rtl/dc_restorer_strobe_edge.sv
// Rising-edge detector for the sample-rate strobe.
//   clk        : system clock
//   reset      : asynchronous active-low reset
//   sampl_freq : level strobe, may stay high for many clocks
//   ev_c       : combinational one-clock event on each rising edge
module strobe_edge (
    input  logic clk,
    input  logic reset,
    input  logic sampl_freq,
    output logic ev_c
);
    logic sf_d;

    // Delayed copy of the strobe
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) sf_d <= 1'b0;
        else        sf_d <= sampl_freq;
    end

    assign ev_c = sampl_freq & ~sf_d;
endmodule

// File: rtl/dc_restorer.sv
// DC restorer: inverse of the DC blocker, H^-1(z) = (1 - a z^-1)/(1 - z^-1)
// with a = 1 - 2^-K. One update per rising edge of sampl_freq; result
// appears 3 clocks after the event with a one-clock data_valid pulse.
//   clk   : system clock
//   reset : asynchronous active-low reset
//   bus   : dc_restorer_if.slave (strobe, clear, data in/out, valid, sat)
// Optional leak term enabled by macro DC_RESTORER_LEAK_EN.
module dc_restorer import dsp_pkg::*; #(
    parameter int unsigned width = WIDTH_DEF,
    parameter int unsigned K     = K_DEF,
    parameter int unsigned GUARD = GUARD_DEF
`ifdef DC_RESTORER_LEAK_EN
    , parameter int unsigned LEAK_SHIFT = 10
`endif
) (
    input  logic         clk,
    input  logic         reset,
    dc_restorer_if.slave bus
);
    localparam int unsigned ACC_W = width + GUARD;

    logic                    ev_c;
    restorer_state_t         state_q;
    restorer_state_t         state_d;
    logic signed [width-1:0] x_r;
    logic signed [width-1:0] x_prev;
    logic signed [ACC_W-1:0] term_r;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] acc_next;
    logic signed [63:0]      sat_wide;
    logic                    clipped_c;
    logic                    v1;
    logic                    v2;

    strobe_edge u_edge (
        .clk        (clk),
        .reset      (reset),
        .sampl_freq (bus.sampl_freq),
        .ev_c       (ev_c)
    );

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= PRIME;
        else        state_q <= state_d;
    end

    // Next state and accumulator update; PRIME bypasses the term path
    always_comb begin
        state_d  = state_q;
        acc_next = acc;
        if (bus.clear) begin
            state_d = PRIME;
        end else if (v2) begin
            if (state_q == PRIME) begin
                acc_next = ACC_W'(x_prev);
                state_d  = RUN;
            end else begin
`ifdef DC_RESTORER_LEAK_EN
                acc_next = acc + term_r - (acc >>> LEAK_SHIFT);
`else
                acc_next = acc + term_r;
`endif
            end
        end
    end

    assign sat_wide  = sat_narrow(64'(acc_next), width);
    assign clipped_c = (sat_wide != 64'(acc_next));

    // Three-stage datapath: capture, term, accumulate + saturate
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v1             <= 1'b0;
            v2             <= 1'b0;
            x_r            <= '0;
            x_prev         <= '0;
            term_r         <= '0;
            acc            <= '0;
            bus.data_out   <= '0;
            bus.data_valid <= 1'b0;
            bus.sat        <= 1'b0;
        end else begin
            v1             <= ev_c & ~bus.clear;
            v2             <= v1 & ~bus.clear;
            bus.data_valid <= 1'b0;
            if (ev_c && !bus.clear) x_r <= bus.data_in;
            if (v1 && !bus.clear) begin
                term_r <= ACC_W'(x_r) - ACC_W'(x_prev) + ACC_W'(x_prev >>> K);
                x_prev <= x_r;
            end
            if (bus.clear) begin
                acc     <= '0;
                bus.sat <= 1'b0;
            end else if (v2) begin
                acc            <= acc_next;
                bus.data_out   <= width'(sat_wide);
                bus.data_valid <= 1'b1;
                if (clipped_c) bus.sat <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_dc_restorer.sv
// Self-checking bench for dc_restorer (width=12, K=4, GUARD=6, no leak).
// Reference model: y[n] = y[n-1] + x[n] - a*x[n-1], first sample primes.
module tb_dc_restorer;
    import dsp_pkg::*;

    localparam int unsigned W = 12;
    localparam longint      ACC_MOD = 64'sd262144;

    logic clk = 1'b0;
    logic reset;

    dc_restorer_if #(.width(W)) bus ();

    dc_restorer #(.width(W), .K(4), .GUARD(6)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int     checks = 0;
    int     errors = 0;
    int     m_prev = 0;
    longint m_acc = 0;
    bit     m_primed = 1'b0;
    bit     m_sat = 1'b0;
    int     exp_out = 0;
    int     got = 0;

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    function automatic longint wrap_acc(input longint v);
        longint r;
        r = (v + ACC_MOD / 2) % ACC_MOD;
        if (r < 0) r = r + ACC_MOD;
        return r - ACC_MOD / 2;
    endfunction

    // Reference: prime on first sample, else integrate x - a*x_prev
    function automatic void model_step(input int x);
        longint t;
        if (!m_primed) begin
            m_acc    = x;
            m_primed = 1'b1;
        end else begin
            t     = longint'(x) - longint'(m_prev) + longint'(m_prev >>> 4);
            m_acc = wrap_acc(m_acc + t);
        end
        m_prev = x;
        if (m_acc > 2047) begin
            exp_out = 2047;
            m_sat   = 1'b1;
        end else if (m_acc < -2048) begin
            exp_out = -2048;
            m_sat   = 1'b1;
        end else begin
            exp_out = int'(m_acc);
        end
    endfunction

    function automatic void model_clear();
        m_primed = 1'b0;
        m_sat    = 1'b0;
        m_acc    = 0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One strobe period: high for hi clocks, data_in scrambled after capture
    task automatic run_event(input int x, input int hi);
        int n;
        int pos;
        n   = 0;
        pos = 0;
        model_step(x);
        bus.data_in    = W'(x);
        bus.sampl_freq = 1'b1;
        for (int c = 1; c <= hi + 4; c++) begin
            tick();
            if (c == hi) bus.sampl_freq = 1'b0;
            if (c == 1) bus.data_in = W'($urandom_range(0, 4095));
            if (bus.data_valid === 1'b1) begin
                n++;
                pos = c;
                got = int'(bus.data_out);
            end
        end
        chk("valid_count", n, 1);
        chk("valid_latency", pos, 3);
        chk("data_out", got, exp_out);
        chk("sat", bus.sat, m_sat);
    endtask

    task automatic pulse_clear();
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        model_clear();
    endtask

    initial begin
        int n;
        reset          = 1'b0;
        bus.sampl_freq = 1'b0;
        bus.clear      = 1'b0;
        bus.data_in    = '0;
        repeat (3) tick();
        chk("rst_data_out", bus.data_out, 0);
        chk("rst_valid", bus.data_valid, 0);
        chk("rst_sat", bus.sat, 0);
        reset = 1'b1;
        tick();

        // Prime and steady input
        run_event(160, 2);
        chk("steady_0", got, 160);
        run_event(160, 3);
        chk("steady_1", got, 170);
        run_event(160, 1);
        chk("steady_2", got, 180);

        // Strobe held high for 40 clocks: one event only
        run_event(37, 40);

        // Positive saturation
        pulse_clear();
        run_event(2047, 2);
        chk("satpos_first", got, 2047);
        chk("satpos_flag0", bus.sat, 0);
        run_event(2047, 2);
        chk("satpos_flag1", bus.sat, 1);
        run_event(2047, 2);
        run_event(2047, 2);
        chk("satpos_last", got, 2047);

        // Clear drops sat, holds data_out; negative mirror
        pulse_clear();
        chk("clear_sat", bus.sat, 0);
        chk("clear_hold", bus.data_out, 2047);
        run_event(-2048, 2);
        chk("satneg_first", got, -2048);
        run_event(-2048, 2);
        chk("satneg_flag", bus.sat, 1);

        // Re-prime after clear
        pulse_clear();
        chk("clear_sat2", bus.sat, 0);
        run_event(-64, 2);
        chk("reprime_0", got, -64);
        run_event(-64, 2);
        chk("reprime_1", got, -68);

        // Clear in the event cycle: event discarded, next event primes
        bus.data_in    = W'(500);
        bus.sampl_freq = 1'b1;
        bus.clear      = 1'b1;
        n = 0;
        for (int c = 1; c <= 6; c++) begin
            tick();
            if (c == 1) bus.clear = 1'b0;
            if (c == 2) bus.sampl_freq = 1'b0;
            if (bus.data_valid === 1'b1) n++;
        end
        model_clear();
        chk("clr_ev_novalid", n, 0);
        run_event(300, 2);
        chk("clr_ev_prime", got, 300);

        // Reset in the middle of the pipeline
        bus.data_in    = W'(-900);
        bus.sampl_freq = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("midrst_data_out", bus.data_out, 0);
        chk("midrst_valid", bus.data_valid, 0);
        chk("midrst_sat", bus.sat, 0);
        bus.sampl_freq = 1'b0;
        n = 0;
        for (int c = 1; c <= 5; c++) begin
            tick();
            if (bus.data_valid === 1'b1) n++;
        end
        chk("midrst_novalid", n, 0);
        reset = 1'b1;
        model_clear();
        m_prev = 0;
        tick();
        run_event(-900, 2);
        chk("midrst_prime", got, -900);

        // Randomized events with occasional clears
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 7) == 0) pulse_clear();
            run_event(int'($urandom_range(0, 4095)) - 2048, int'($urandom_range(1, 6)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/dc_restorer.md
Name: dc_restorer

Overview:
- Inverse of the DC blocker: applies H⁻¹(z) = (1 − a·z⁻¹)/(1 − z⁻¹), with a = 1 − 2^-K.
- The DC blocker output enters this block, and the block reconstructs the baseline-bearing waveform from it.
- Used in loopback verification of the DC blocker chain and as a baseline-restoring stage ahead of pulse-height logic.
- Updates once per rising edge of the sample-rate strobe sampl_freq, with saturating output arithmetic.

Parameters:
- width, 12, signed data width of data_in and data_out.
- K, 4, pole shift; a = 1 − 2^-K, and K must match the DC blocker setting.
- GUARD, 6, extra accumulator bits above width.
- LEAK_SHIFT, 10, leak shift; used only when DC_RESTORER_LEAK_EN is defined.

Ports:
- clk  in  1  system clock, rising-edge active.
- reset  in  1  asynchronous, active-low reset.
- sampl_freq  in  1  sample-rate strobe (level signal, may span many clocks); one update per rising edge.
- clear  in  1  synchronous; re-primes the filter on the next sample.
- data_in  in  width  signed sample from the DC blocker.
- data_out  out  width  signed restored sample, saturated.
- data_valid  out  1  one-clock pulse when data_out updates.
- sat  out  1  sticky flag: accumulator exceeded the width range since the last reset or clear.

Behaviour:
- Reset (reset=0, asynchronous): clears every register. data_out=0, data_valid=0, sat=0, acc=0, x_prev=0, sf_d=0, state=PRIME.
- Edge detect: sf_d <= sampl_freq. Sample event ev = sampl_freq & ~sf_d.
  - Holding sampl_freq high produces exactly one event.
  - A glitch-free square wave of any duty cycle gives one event per period.
- Pipeline, with E = the cycle in which ev is asserted:
  - E: capture data_in into x_r.
  - E+1: compute term = x_r − x_prev + (x_prev >>> K), sign-extended to width+GUARD. x_prev <= x_r.
  - E+2: acc <= acc + term, in width+GUARD bits with two's-complement wrap. The accumulator never saturates internally.
  - E+3: data_out <= sat(acc) clipped to [−2^(width−1), 2^(width−1)−1]. data_valid=1 for exactly this cycle. sat sets if clipping occurred.
  - Latency is 3 clocks from E to data_valid. Events closer than 4 clocks apart are unsupported (sampl_freq is far slower).
- States:
  - PRIME: on the first event, acc <= sign-extended x_r and x_prev <= x_r. The term path is bypassed, so the output equals the input. Then go to RUN.
  - RUN: normal recursion as above.
  - clear=1 in any cycle: state <= PRIME, sat <= 0, acc <= 0. The pipeline in flight is flushed and data_valid is suppressed for it. data_out holds its last value.
- Simultaneous clear and ev: clear wins; the event is discarded.
- Reset mid-pipeline: everything is flushed immediately and no data_valid pulse occurs.

Optional Feature:
- Macro DC_RESTORER_LEAK_EN.
  - Defined: at stage E+2, acc <= acc + term − (acc >>> LEAK_SHIFT). This bounds drift from rounding mismatch with the blocker.
  - Undefined: pure integrator as above, and LEAK_SHIFT is unused. Exact inverse of the blocker, but it can drift with offsets.

Decomposition:
- Shared package dsp_pkg holds:
  - typedef enum logic {PRIME, RUN} restorer_state_t;
  - localparam defaults for width, K and GUARD;
  - a function sat_narrow(acc, width), shared with the DC blocker.
- One natural sub-module: strobe_edge, the sampl_freq rising-edge detector. It is reusable by the DC blocker.

Test Plan (width=12, K=4, leak disabled):
- Prime and steady input:
  - Stimulus: reset pulse, then data_in=160 held over 3 sampl_freq periods.
  - Response: data_out = 160, 170, 180 (increment 160>>>4 = 10). data_valid pulses exactly 3 clocks after each rising edge.
- Strobe held high:
  - Stimulus: sampl_freq high for 40 clocks.
  - Response: exactly one data_valid pulse.
- Saturation:
  - Stimulus: data_in=2047 over 4 events.
  - Response: data_out=2047 from the first event onward, and sat=1 from the second event (accumulator 2047 + 127 exceeds the range).
  - Negative mirror: data_in=−2048 gives data_out=−2048.
- Clear:
  - Stimulus: after the saturation test, clear=1 for 1 clock, then data_in=−64.
  - Response: sat=0. The next output is −64 (re-primed), then −68.
- Clear and event in the same cycle:
  - Stimulus: assert clear in cycle E.
  - Response: no data_valid for that event, and the following event primes.
- Reset mid-pipeline:
  - Stimulus: drive reset=0 at E+1.
  - Response: data_out=0, no data_valid pulse, and the next event after release primes with data_in.
